// File: rtl/comp_serializer.sv
// Parallel-to-serial operand feeder for the bit-serial comparator.
// Define COMP_SER_LSB_FIRST_EN to emit bit 0 first (default MSB-first).
module comp_serializer #(
  parameter int BIT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BIT_LEN-1:0] a_in,
  input  logic [BIT_LEN-1:0] b_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic               comp_reset,
  output logic               a_out,
  output logic               b_out,
  output logic               out_valid,
  output logic               done
);

  localparam int CW = $clog2(BIT_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_state;
  logic [BIT_LEN-1:0] r_a_sr;
  logic [BIT_LEN-1:0] r_b_sr;
  logic [BIT_LEN-1:0] w_a_sr;
  logic [BIT_LEN-1:0] w_b_sr;
  logic [BIT_LEN-1:0] w_a_shf;
  logic [BIT_LEN-1:0] w_b_shf;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt;
  logic               w_a_bit;
  logic               w_b_bit;
  logic               w_emit;
  logic               w_comp_reset;
  logic               w_a_out;
  logic               w_b_out;
  logic               w_out_valid;
  logic               w_done;

`ifdef COMP_SER_LSB_FIRST_EN
  assign w_a_bit = r_a_sr[0];
  assign w_b_bit = r_b_sr[0];
  assign w_a_shf = r_a_sr >> 1;
  assign w_b_shf = r_b_sr >> 1;
`else
  assign w_a_bit = r_a_sr[BIT_LEN-1];
  assign w_b_bit = r_b_sr[BIT_LEN-1];
  assign w_a_shf = r_a_sr << 1;
  assign w_b_shf = r_b_sr << 1;
`endif

  assign in_ready = (r_state == IDLE) && reset;

  // Outputs are computed for the next cycle and registered below.
  always_comb begin
    w_state      = r_state;
    w_a_sr       = r_a_sr;
    w_b_sr       = r_b_sr;
    w_cnt        = r_cnt;
    w_emit       = 1'b0;
    w_comp_reset = 1'b1;
    w_a_out      = 1'b0;
    w_b_out      = 1'b0;
    w_out_valid  = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_state = CLEAR;
          w_a_sr  = a_in;
          w_b_sr  = b_in;
          w_cnt   = '0;
        end
      end
      CLEAR: begin
        w_state = SHIFT;
        w_emit  = 1'b1;
      end
      SHIFT: begin
        if (r_cnt == LAST) begin
          w_state      = DONE;
          w_done       = 1'b1;
          w_comp_reset = 1'b0;
        end else begin
          w_emit = 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    if (w_emit) begin
      w_comp_reset = 1'b0;
      w_out_valid  = 1'b1;
      w_a_out      = w_a_bit;
      w_b_out      = w_b_bit;
      w_a_sr       = w_a_shf;
      w_b_sr       = w_b_shf;
      w_cnt        = r_cnt + CW'(1);
    end

    // A cancelled frame looks exactly like a return to idle.
    if (abort && (r_state != IDLE)) begin
      w_state      = IDLE;
      w_a_sr       = '0;
      w_b_sr       = '0;
      w_cnt        = '0;
      w_comp_reset = 1'b1;
      w_a_out      = 1'b0;
      w_b_out      = 1'b0;
      w_out_valid  = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_cnt      <= '0;
      comp_reset <= 1'b1;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_a_sr     <= w_a_sr;
      r_b_sr     <= w_b_sr;
      r_cnt      <= w_cnt;
      comp_reset <= w_comp_reset;
      a_out      <= w_a_out;
      b_out      <= w_b_out;
      out_valid  <= w_out_valid;
      done       <= w_done;
    end
  end

endmodule
